mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Sequencer for the MEM stage of the five-stage pipeline. It takes the load/store decoded into the EX/MEM pipeline register and runs it against a variable-latency data memory through a req/ack handshake. While the access is in flight it holds the pipeline with a stall. It also captures load data, checks word alignment, and bounds each access with a timeout that raises a bus error.

## Interface
- TIMEOUT, 16: max cycles in REQ waiting for ack before bus error (≥1)
- CNT_W, 5: width of the wait counter; must hold TIMEOUT
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- memread_MEM  in  1  load in EX/MEM register
- memwrite_MEM  in  1  store in EX/MEM register
- ALU_data_MEM  in  32  effective byte address
- store_data_MEM  in  32  store data
- dmem_ack  in  1  memory completion; valid only while dmem_req=1
- dmem_rdata  in  32  read data, valid with dmem_ack on a read
- dmem_req  out  1  access request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  32  word address (latched, bits[1:0]=00)
- dmem_wdata  out  32  latched store data
- stall_pipe  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- load_data  out  32  captured read data
- load_valid  out  1  one-cycle pulse: load_data valid for writeback
- bus_err  out  1  one-cycle pulse: misaligned, illegal or timed-out access

## Operation
- States: IDLE, REQ, DONE, ERR. Encoding is free.
- IDLE:
  - No access (memread_MEM=memwrite_MEM=0): stall_pipe=0, stay in IDLE.
  - Access present: stall_pipe=1 combinationally, same cycle.
  - Aligned (addr[1:0]=00) and exactly one of read/write:
    - Latch addr, we=memwrite_MEM, wdata.
    - Clear the counter.
    - Go to REQ.
  - Misaligned, or memread_MEM and memwrite_MEM both 1: go to ERR. No request is issued.
- REQ:
  - dmem_req=1; addr/we/wdata held stable; stall_pipe=1.
  - On dmem_ack:
    - Read: load_data<=dmem_rdata.
    - Write: load_data unchanged.
    - Go to DONE.
  - No ack: counter++.
  - Counter reaches TIMEOUT-1 without ack: go to ERR and drop dmem_req. Any later ack is ignored.
- DONE:
  - stall_pipe=0.
  - load_valid=1 only if the access was a read.
  - Go to IDLE unconditionally. The pipeline advances at this edge, so the same instruction is never re-issued.
- ERR:
  - stall_pipe=0, bus_err=1, load_valid=0, load_data<=0.
  - Go to IDLE unconditionally.
- dmem_ack in IDLE/DONE/ERR is ignored.
- dmem_req is never asserted outside REQ.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - load_data=0, load_valid=0, bus_err=0.
  - stall_pipe is combinational: 0 during reset.
- Latency, ack on first REQ cycle:
  - Cycle 0 IDLE, stall=1.
  - Cycle 1 REQ with ack.
  - Cycle 2 DONE, load_valid=1, stall=0.
  - Result: 2 stall cycles, new instruction evaluated in cycle 3.
- General: ack in the k-th REQ cycle (k≥1) gives k+1 stall cycles.
- Timeout: dmem_req is high for exactly TIMEOUT cycles. Stall is asserted for TIMEOUT+1 cycles. bus_err appears the following cycle.
- Misaligned: 1 stall cycle (IDLE), then ERR.
- Ack on the same edge as the timeout limit: ack wins, go to DONE.
- Back-to-back accesses: DONE→IDLE; the next access starts its stall in the IDLE cycle after DONE.
- Reset mid-REQ: dmem_req drops asynchronously. No load_valid or bus_err pulse is produced.

## Test plan
- Aligned load, addr 0x0000_0010, ack on 1st REQ cycle, rdata 0xDEAD_BEEF:
  - Required: stall high 2 cycles.
  - Required: dmem_addr=0x10, we=0, req 1 cycle.
  - Required: load_valid pulse with load_data=0xDEAD_BEEF.
- Store, addr 0x20, wdata 0x1234_5678, ack after 3 REQ cycles:
  - Required: req held 3 cycles with stable addr/we=1/wdata.
  - Required: stall 4 cycles, no load_valid, no bus_err.
- Load with no ack, TIMEOUT=4:
  - Required: req high exactly 4 cycles.
  - Required: bus_err pulse, load_data=0, stall released.
  - Required: a late ack is ignored.
- Misaligned load, addr 0x0000_0013; and a case with memread_MEM=memwrite_MEM=1:
  - Required: dmem_req never high.
  - Required: 1 stall cycle, then bus_err pulse.
- Back-to-back loads at 0x0 then 0x4, ack immediate:
  - Required: two separate req pulses, 2 stall cycles each.
  - Required: two load_valid pulses with the correct data.
- Assert reset during REQ cycle 2:
  - Required: dmem_req/stall drop the same cycle.
  - Required: all outputs at reset values.
  - Required: IDLE after release, and the next access behaves normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage load/store sequencer with req/ack handshake and timeout
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_MEM,
    input  logic        memwrite_MEM,
    input  logic [31:0] ALU_data_MEM,
    input  logic [31:0] store_data_MEM,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        stall_pipe,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             access, start_ok, stall_c;

    assign access   = memread_MEM | memwrite_MEM;
    assign start_ok = access && (ALU_data_MEM[1:0] == 2'b00) && (memread_MEM ^ memwrite_MEM);

    always_comb begin
        state_nxt  = state;
        stall_c    = 1'b0;
        dmem_req   = 1'b0;
        load_valid = 1'b0;
        bus_err    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall_c   = 1'b1;
                    state_nxt = start_ok ? REQ : ERR;
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                stall_c  = 1'b1;
                // ack takes priority over the timeout limit on the same cycle
                if (dmem_ack)
                    state_nxt = DONE;
                else if (cnt == CNT_LAST)
                    state_nxt = ERR;
            end
            DONE: begin
                load_valid = ~dmem_we;
                state_nxt  = IDLE;
            end
            ERR: begin
                bus_err   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_pipe = stall_c & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        dmem_addr  <= {ALU_data_MEM[31:2], 2'b00};
                        dmem_we    <= memwrite_MEM;
                        dmem_wdata <= store_data_MEM;
                        cnt        <= '0;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        if (!dmem_we)
                            load_data <= dmem_rdata;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // cleared on entry so the bus_err cycle already shows zero data
            if (state_nxt == ERR)
                load_data <= '0;
        end
    end

endmodule
